// File: rtl/rv4028_bus_pkg.sv
// Shared types and constants for the RV4028 16-bit bus sequencer.
package rv4028_bus_pkg;

  typedef enum logic [2:0] {StIdle, StT1, StT2, StTw, StT3} cyc_state_e;
  typedef enum logic [1:0] {SqIdle, SqRun, SqBusrel} seq_state_e;
  typedef enum logic {HalfLo, HalfHi} half_e;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        is_read;
    logic        is_io;
  } req_t;

  // DDR pair encoding: bit 0 drives the clock-high phase, bit 1 the clock-low phase.
  localparam logic [1:0] DDR_HI   = 2'b11;
  localparam logic [1:0] DDR_FALL = 2'b01;
  localparam logic [1:0] DDR_LO   = 2'b00;
  localparam logic [1:0] DDR_RISE = 2'b10;

  localparam logic [3:0] IO_NIBBLE_DEF = 4'hF;

  function automatic half_e first_half(input req_t r);
    half_e h;
    if (r.is_read || (r.wmask[1:0] != 2'b00)) h = HalfLo;
    else h = HalfHi;
    return h;
  endfunction

  function automatic logic needs_hi(input req_t r);
    return r.is_read || (r.wmask[3:2] != 2'b00);
  endfunction

endpackage

// File: rtl/rv4028_bus_cycle.sv
// One 16-bit T1/T2/TW/T3 bus cycle; a new start may chain directly out of T3.
module rv4028_bus_cycle
  import rv4028_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] addr_i,
  input  logic [15:0] wdata_i,
  input  logic [1:0]  msk_n_i,
  input  logic        is_read_i,
  input  logic        is_io_i,
  input  logic        wait_n_i,
  input  logic [15:0] data_in_i,
  output logic        done_o,
  output logic [15:0] rdata_o,
  output logic [31:0] addr_o,
  output logic [15:0] data_out_o,
  output logic        data_oe_o,
  output logic [1:0]  msk_n_o,
  output logic        rd_n_o,
  output logic [1:0]  wr_n_o,
  output logic [1:0]  mreq_n_o,
  output logic        iorq_n_o
);

  cyc_state_e  state_q, state_d;
  logic        is_read_q, is_read_d;
  logic        is_io_q, is_io_d;
  logic [15:0] rdata_q, rdata_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] data_out_q, data_out_d;
  logic        data_oe_q, data_oe_d;
  logic [1:0]  msk_n_q, msk_n_d;
  logic        rd_n_q, rd_n_d;
  logic [1:0]  wr_n_q, wr_n_d;
  logic [1:0]  mreq_n_q, mreq_n_d;
  logic        iorq_n_q, iorq_n_d;

  always_comb begin
    state_d    = state_q;
    is_read_d  = is_read_q;
    is_io_d    = is_io_q;
    rdata_d    = rdata_q;
    addr_d     = addr_q;
    data_out_d = data_out_q;
    data_oe_d  = data_oe_q;
    msk_n_d    = msk_n_q;
    rd_n_d     = rd_n_q;
    wr_n_d     = wr_n_q;
    mreq_n_d   = mreq_n_q;
    iorq_n_d   = iorq_n_q;
    unique case (state_q)
      StIdle, StT3: begin
        if (start_i) begin
          state_d   = StT1;
          is_read_d = is_read_i;
          is_io_d   = is_io_i;
          addr_d    = addr_i;
          if (!is_read_i) data_out_d = wdata_i;
          data_oe_d = ~is_read_i;
          msk_n_d   = msk_n_i;
          rd_n_d    = ~is_read_i;
          wr_n_d    = DDR_HI;
          mreq_n_d  = is_io_i ? DDR_HI : DDR_FALL;
          iorq_n_d  = ~is_io_i;
        end else begin
          state_d   = StIdle;
          data_oe_d = 1'b0;
          msk_n_d   = 2'b11;
          rd_n_d    = 1'b1;
          wr_n_d    = DDR_HI;
          mreq_n_d  = DDR_HI;
          iorq_n_d  = 1'b1;
        end
      end
      StT1: begin
        state_d  = StT2;
        mreq_n_d = is_io_q ? DDR_HI : DDR_LO;
        wr_n_d   = is_read_q ? DDR_HI : DDR_LO;
      end
      StT2, StTw: begin
        // TW keeps every strobe exactly as in T2.
        if (wait_n_i) begin
          state_d  = StT3;
          mreq_n_d = is_io_q ? DDR_HI : DDR_RISE;
          wr_n_d   = is_read_q ? DDR_HI : DDR_RISE;
          if (is_read_q) rdata_d = data_in_i;
        end else begin
          state_d = StTw;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      is_read_q  <= 1'b0;
      is_io_q    <= 1'b0;
      rdata_q    <= 16'h0000;
      addr_q     <= 32'h0000_0000;
      data_out_q <= 16'h0000;
      data_oe_q  <= 1'b0;
      msk_n_q    <= 2'b11;
      rd_n_q     <= 1'b1;
      wr_n_q     <= DDR_HI;
      mreq_n_q   <= DDR_HI;
      iorq_n_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      is_read_q  <= is_read_d;
      is_io_q    <= is_io_d;
      rdata_q    <= rdata_d;
      addr_q     <= addr_d;
      data_out_q <= data_out_d;
      data_oe_q  <= data_oe_d;
      msk_n_q    <= msk_n_d;
      rd_n_q     <= rd_n_d;
      wr_n_q     <= wr_n_d;
      mreq_n_q   <= mreq_n_d;
      iorq_n_q   <= iorq_n_d;
    end
  end

  assign done_o     = (state_q == StT3);
  assign rdata_o    = rdata_q;
  assign addr_o     = addr_q;
  assign data_out_o = data_out_q;
  assign data_oe_o  = data_oe_q;
  assign msk_n_o    = msk_n_q;
  assign rd_n_o     = rd_n_q;
  assign wr_n_o     = wr_n_q;
  assign mreq_n_o   = mreq_n_q;
  assign iorq_n_o   = iorq_n_q;

endmodule

// File: rtl/rv4028_bus_seq.sv
// Splits 32-bit core accesses into 16-bit RV4028 bus cycles; handles bus release.
module rv4028_bus_seq
  import rv4028_bus_pkg::*;
#(
  parameter logic [3:0] IO_NIBBLE = IO_NIBBLE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  input  logic        mem_rstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_rbusy,
  output logic        mem_wbusy,
  output logic [31:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_oe,
  output logic [1:0]  msk_n,
  output logic        rd_n,
  output logic [1:0]  wr_n,
  output logic [1:0]  mreq_n,
  output logic        iorq_n,
  input  logic        wait_n,
  input  logic        busrq_n,
  output logic        busack_n
);

  seq_state_e  state_q, state_d;
  req_t        cur_q, cur_d, pend_q, pend_d, new_req, st_req;
  logic        cur_valid_q, cur_valid_d, pend_valid_q, pend_valid_d;
  half_e       half_q, half_d, st_half;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        rbusy_q, rbusy_d, wbusy_q, wbusy_d, busack_n_q, busack_n_d;
  logic        cyc_start, cyc_done, launch;
  logic [15:0] cyc_rdata;
  logic [31:0] st_addr;
  logic [15:0] st_wdata;
  logic [1:0]  st_msk_n;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^mem_addr[1:0];

  always_comb begin
    new_req.waddr   = mem_addr[31:2];
    new_req.wdata   = mem_wdata;
    new_req.wmask   = mem_wmask;
    new_req.is_read = (mem_wmask == 4'b0000);
    new_req.is_io   = (mem_addr[31:28] == IO_NIBBLE);

    state_d      = state_q;
    cur_d        = cur_q;
    cur_valid_d  = cur_valid_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    half_d       = half_q;
    mem_rdata_d  = mem_rdata_q;
    cyc_start    = 1'b0;
    launch       = 1'b0;
    st_req       = cur_q;
    st_half      = HalfHi;

    unique case (state_q)
      SqIdle: begin
        if (!busrq_n) state_d = SqBusrel;
        else if (pend_valid_q) launch = 1'b1;
      end
      SqRun: begin
        if (cyc_done) begin
          if (cur_q.is_read) begin
            if (half_q == HalfHi) mem_rdata_d[31:16] = cyc_rdata;
            else mem_rdata_d[15:0] = cyc_rdata;
          end
          if ((half_q == HalfLo) && needs_hi(cur_q)) begin
            cyc_start = 1'b1;
            half_d    = HalfHi;
          end else begin
            // Transaction boundary: the only point where busrq_n is honoured.
            cur_valid_d = 1'b0;
            if (!busrq_n) state_d = SqBusrel;
            else if (pend_valid_q) launch = 1'b1;
            else state_d = SqIdle;
          end
        end
      end
      SqBusrel: begin
        if (busrq_n) state_d = SqIdle;
      end
      default: state_d = SqIdle;
    endcase

    if (launch) begin
      cyc_start    = 1'b1;
      st_req       = pend_q;
      st_half      = first_half(pend_q);
      half_d       = st_half;
      cur_d        = pend_q;
      cur_valid_d  = 1'b1;
      pend_valid_d = 1'b0;
      state_d      = SqRun;
    end

    if ((mem_rstrb || (mem_wmask != 4'b0000)) && !pend_valid_q) begin
      pend_d       = new_req;
      pend_valid_d = 1'b1;
    end

    rbusy_d    = (cur_valid_d && cur_d.is_read) || (pend_valid_d && pend_d.is_read);
    wbusy_d    = (cur_valid_d && !cur_d.is_read) || (pend_valid_d && !pend_d.is_read);
    busack_n_d = (state_d != SqBusrel);

    if (st_half == HalfHi) begin
      st_addr  = {st_req.waddr, 2'b10};
      st_wdata = st_req.wdata[31:16];
      st_msk_n = st_req.is_read ? 2'b00 : ~st_req.wmask[3:2];
    end else begin
      st_addr  = {st_req.waddr, 2'b00};
      st_wdata = st_req.wdata[15:0];
      st_msk_n = st_req.is_read ? 2'b00 : ~st_req.wmask[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SqIdle;
      cur_q        <= '0;
      cur_valid_q  <= 1'b0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      half_q       <= HalfLo;
      mem_rdata_q  <= 32'h0000_0000;
      rbusy_q      <= 1'b0;
      wbusy_q      <= 1'b0;
      busack_n_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      cur_valid_q  <= cur_valid_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      half_q       <= half_d;
      mem_rdata_q  <= mem_rdata_d;
      rbusy_q      <= rbusy_d;
      wbusy_q      <= wbusy_d;
      busack_n_q   <= busack_n_d;
    end
  end

  rv4028_bus_cycle u_cycle (
    .clk        (clk),
    .rst        (rst),
    .start_i    (cyc_start),
    .addr_i     (st_addr),
    .wdata_i    (st_wdata),
    .msk_n_i    (st_msk_n),
    .is_read_i  (st_req.is_read),
    .is_io_i    (st_req.is_io),
    .wait_n_i   (wait_n),
    .data_in_i  (data_in),
    .done_o     (cyc_done),
    .rdata_o    (cyc_rdata),
    .addr_o     (addr),
    .data_out_o (data_out),
    .data_oe_o  (data_oe),
    .msk_n_o    (msk_n),
    .rd_n_o     (rd_n),
    .wr_n_o     (wr_n),
    .mreq_n_o   (mreq_n),
    .iorq_n_o   (iorq_n)
  );

  assign mem_rdata = mem_rdata_q;
  assign mem_rbusy = rbusy_q;
  assign mem_wbusy = wbusy_q;
  assign busack_n  = busack_n_q;

endmodule

// File: tb/tb_rv4028_bus_seq.sv
// Directed bench for rv4028_bus_seq with a small combinational bus memory.
module tb_rv4028_bus_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, addr;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb, mem_rbusy, mem_wbusy;
  logic [15:0] data_in, data_out;
  logic        data_oe, rd_n, iorq_n, wait_n, busrq_n, busack_n;
  logic [1:0]  msk_n, wr_n, mreq_n;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rv4028_bus_seq dut (
    .clk       (clk),
    .rst       (rst),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_rstrb (mem_rstrb),
    .mem_rdata (mem_rdata),
    .mem_rbusy (mem_rbusy),
    .mem_wbusy (mem_wbusy),
    .addr      (addr),
    .data_in   (data_in),
    .data_out  (data_out),
    .data_oe   (data_oe),
    .msk_n     (msk_n),
    .rd_n      (rd_n),
    .wr_n      (wr_n),
    .mreq_n    (mreq_n),
    .iorq_n    (iorq_n),
    .wait_n    (wait_n),
    .busrq_n   (busrq_n),
    .busack_n  (busack_n)
  );

  function automatic logic [15:0] bus_mem(input logic [31:0] a);
    case (a)
      32'h0000_1000: return 16'h1234;
      32'h0000_1002: return 16'hABCD;
      32'h0000_1004: return 16'h0F0F;
      32'h0000_1006: return 16'h7E57;
      32'hF000_0010: return 16'h5555;
      32'hF000_0012: return 16'hAAAA;
      default:       return 16'h0000;
    endcase
  endfunction

  // Garbage while wait_n is low, so only a capture on a high sample is correct.
  assign data_in = wait_n ? bus_mem(addr) : 16'hDEAD;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_addr = '0; mem_wdata = '0; mem_wmask = '0; mem_rstrb = 1'b0;
    wait_n = 1'b1; busrq_n = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    n_cmp++;
    if ({addr, data_out, data_oe, msk_n, rd_n, wr_n, mreq_n, iorq_n} !==
        {32'h0, 16'h0, 1'b0, 2'b11, 1'b1, 2'b11, 2'b11, 1'b1}) begin
      n_err++;
      $display("FAIL reset_bus: addr=%h dout=%h oe=%b msk=%b rd=%b wr=%b mreq=%b iorq=%b",
               addr, data_out, data_oe, msk_n, rd_n, wr_n, mreq_n, iorq_n);
    end
    n_cmp++;
    if ({busack_n, mem_rbusy, mem_wbusy, mem_rdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL reset_core: busack=%b rbusy=%b wbusy=%b rdata=%h (want 1 0 0 0)",
               busack_n, mem_rbusy, mem_wbusy, mem_rdata);
    end
  endtask

  task automatic test_read();
    logic [11:0] seq = 12'b01_00_10_01_00_10;
    logic [31:0] ea;
    mem_addr = 32'h0000_1000; mem_rstrb = 1'b1;
    step();
    mem_rstrb = 1'b0;
    n_cmp++;
    if (mem_rbusy !== 1'b1) begin
      n_err++; $display("FAIL read_busy_rise: got %b want 1", mem_rbusy);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      ea = (i < 3) ? 32'h0000_1000 : 32'h0000_1002;
      n_cmp++;
      if ({addr, mreq_n, rd_n, iorq_n, mem_rbusy} !== {ea, seq[11-2*i -: 2], 1'b0, 1'b1, 1'b1})
      begin
        n_err++;
        $display("FAIL read_t%0d: addr=%h mreq=%b rd=%b iorq=%b busy=%b want %h %b 0 1 1",
                 i, addr, mreq_n, rd_n, iorq_n, mem_rbusy, ea, seq[11-2*i -: 2]);
      end
    end
    step();
    n_cmp++;
    if ({mem_rbusy, mem_rdata, rd_n, mreq_n} !== {1'b0, 32'hABCD_1234, 1'b1, 2'b11}) begin
      n_err++;
      $display("FAIL read_done: busy=%b rdata=%h rd=%b mreq=%b want 0 abcd1234 1 11",
               mem_rbusy, mem_rdata, rd_n, mreq_n);
    end
  endtask

  task automatic test_write_hi();
    mem_addr = 32'h0000_2000; mem_wdata = 32'hDEAD_BEEF; mem_wmask = 4'b1100;
    step();
    mem_wmask = 4'b0000;
    n_cmp++;
    if ({mem_wbusy, mem_rbusy} !== 2'b10) begin
      n_err++; $display("FAIL wr_hi_busy: w=%b r=%b want 1 0", mem_wbusy, mem_rbusy);
    end
    step();
    n_cmp++;
    if ({addr, data_out, data_oe, msk_n, wr_n, mreq_n, rd_n} !==
        {32'h0000_2002, 16'hDEAD, 1'b1, 2'b00, 2'b11, 2'b01, 1'b1}) begin
      n_err++;
      $display("FAIL wr_hi_t1: addr=%h dout=%h oe=%b msk=%b wr=%b mreq=%b rd=%b",
               addr, data_out, data_oe, msk_n, wr_n, mreq_n, rd_n);
    end
    step();
    n_cmp++;
    if ({wr_n, mreq_n, data_oe} !== {2'b00, 2'b00, 1'b1}) begin
      n_err++; $display("FAIL wr_hi_t2: wr=%b mreq=%b oe=%b want 00 00 1", wr_n, mreq_n, data_oe);
    end
    step();
    n_cmp++;
    if ({wr_n, mreq_n, data_oe, data_out} !== {2'b10, 2'b10, 1'b1, 16'hDEAD}) begin
      n_err++;
      $display("FAIL wr_hi_t3: wr=%b mreq=%b oe=%b dout=%h want 10 10 1 dead",
               wr_n, mreq_n, data_oe, data_out);
    end
    step();
    n_cmp++;
    if ({mem_wbusy, wr_n, mreq_n, data_oe} !== {1'b0, 2'b11, 2'b11, 1'b0}) begin
      n_err++;
      $display("FAIL wr_hi_done: busy=%b wr=%b mreq=%b oe=%b want 0 11 11 0",
               mem_wbusy, wr_n, mreq_n, data_oe);
    end
  endtask

  task automatic test_write_lo();
    mem_addr = 32'h0000_3000; mem_wdata = 32'h1234_BEEF; mem_wmask = 4'b0001;
    step();
    mem_wmask = 4'b0000;
    step();
    n_cmp++;
    if ({addr, data_out, msk_n, mreq_n} !== {32'h0000_3000, 16'hBEEF, 2'b10, 2'b01}) begin
      n_err++;
      $display("FAIL wr_lo_t1: addr=%h dout=%h msk=%b mreq=%b want 00003000 beef 10 01",
               addr, data_out, msk_n, mreq_n);
    end
    step(); step(); step();
    n_cmp++;
    if ({mem_wbusy, mreq_n} !== {1'b0, 2'b11}) begin
      n_err++; $display("FAIL wr_lo_done: busy=%b mreq=%b want 0 11", mem_wbusy, mreq_n);
    end
  endtask

  task automatic test_io_read();
    mem_addr = 32'hF000_0010; mem_rstrb = 1'b1;
    step();
    mem_rstrb = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      n_cmp++;
      if ({iorq_n, mreq_n, rd_n} !== {1'b0, 2'b11, 1'b0}) begin
        n_err++;
        $display("FAIL io_t%0d: iorq=%b mreq=%b rd=%b want 0 11 0", i, iorq_n, mreq_n, rd_n);
      end
    end
    step();
    n_cmp++;
    if ({iorq_n, mem_rbusy, mem_rdata} !== {1'b1, 1'b0, 32'hAAAA_5555}) begin
      n_err++;
      $display("FAIL io_done: iorq=%b busy=%b rdata=%h want 1 0 aaaa5555",
               iorq_n, mem_rbusy, mem_rdata);
    end
  endtask

  task automatic test_wait();
    mem_addr = 32'h0000_1000; mem_rstrb = 1'b1;
    step();
    mem_rstrb = 1'b0;
    step(); step();
    wait_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if ({mreq_n, rd_n} !== {2'b00, 1'b0}) begin
        n_err++; $display("FAIL wait_tw%0d: mreq=%b rd=%b want 00 0", i, mreq_n, rd_n);
      end
    end
    wait_n = 1'b1;
    step();
    n_cmp++;
    if (mreq_n !== 2'b10) begin
      n_err++; $display("FAIL wait_t3: mreq=%b want 10", mreq_n);
    end
    repeat (3) step();
    n_cmp++;
    if (mem_rbusy !== 1'b1) begin
      n_err++; $display("FAIL wait_busy_hold: busy=%b want 1", mem_rbusy);
    end
    step();
    n_cmp++;
    if ({mem_rbusy, mem_rdata} !== {1'b0, 32'hABCD_1234}) begin
      n_err++;
      $display("FAIL wait_done: busy=%b rdata=%h want 0 abcd1234", mem_rbusy, mem_rdata);
    end
  endtask

  task automatic test_busrq();
    int cyc;
    mem_addr = 32'h0000_1000; mem_rstrb = 1'b1;
    step();
    mem_rstrb = 1'b0;
    step(); step();
    busrq_n = 1'b0;
    step(); step();
    n_cmp++;
    if ({busack_n, mem_rbusy} !== 2'b11) begin
      n_err++; $display("FAIL busrq_mid: busack=%b busy=%b want 1 1", busack_n, mem_rbusy);
    end
    repeat (3) step();
    n_cmp++;
    if ({busack_n, mem_rbusy, mem_rdata} !== {1'b0, 1'b0, 32'hABCD_1234}) begin
      n_err++;
      $display("FAIL busrq_grant: busack=%b busy=%b rdata=%h want 0 0 abcd1234",
               busack_n, mem_rbusy, mem_rdata);
    end
    mem_addr = 32'h0000_1004; mem_rstrb = 1'b1;
    step();
    mem_rstrb = 1'b0;
    step(); step();
    n_cmp++;
    if ({mem_rbusy, busack_n, rd_n, mreq_n, data_oe} !== {1'b1, 1'b0, 1'b1, 2'b11, 1'b0}) begin
      n_err++;
      $display("FAIL busrel_hold: busy=%b busack=%b rd=%b mreq=%b oe=%b want 1 0 1 11 0",
               mem_rbusy, busack_n, rd_n, mreq_n, data_oe);
    end
    busrq_n = 1'b1;
    step();
    n_cmp++;
    if ({busack_n, mreq_n} !== {1'b1, 2'b11}) begin
      n_err++; $display("FAIL busrel_exit: busack=%b mreq=%b want 1 11", busack_n, mreq_n);
    end
    step();
    n_cmp++;
    if ({addr, mreq_n} !== {32'h0000_1004, 2'b01}) begin
      n_err++; $display("FAIL busrel_t1: addr=%h mreq=%b want 00001004 01", addr, mreq_n);
    end
    cyc = 0;
    while (mem_rbusy === 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    n_cmp++;
    if ({cyc[7:0], mem_rbusy, mem_rdata} !== {8'd6, 1'b0, 32'h7E57_0F0F}) begin
      n_err++;
      $display("FAIL busrel_read: cycles=%0d busy=%b rdata=%h want 6 0 7e570f0f",
               cyc, mem_rbusy, mem_rdata);
    end
  endtask

  task automatic test_reset_in_wait();
    mem_addr = 32'h0000_1000; mem_rstrb = 1'b1; wait_n = 1'b0;
    step();
    mem_rstrb = 1'b0;
    repeat (3) step();
    n_cmp++;
    if ({mreq_n, rd_n, mem_rbusy} !== {2'b00, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL rst_tw_pre: mreq=%b rd=%b busy=%b want 00 0 1",
                        mreq_n, rd_n, mem_rbusy);
    end
    rst = 1'b1;
    step();
    n_cmp++;
    if ({addr, data_out, data_oe, msk_n, rd_n, wr_n, mreq_n, iorq_n, busack_n,
         mem_rbusy, mem_wbusy, mem_rdata} !==
        {32'h0, 16'h0, 1'b0, 2'b11, 1'b1, 2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL rst_tw: addr=%h dout=%h oe=%b msk=%b rd=%b wr=%b mreq=%b iorq=%b ack=%b rb=%b wb=%b rdata=%h",
               addr, data_out, data_oe, msk_n, rd_n, wr_n, mreq_n, iorq_n, busack_n,
               mem_rbusy, mem_wbusy, mem_rdata);
    end
    rst = 1'b0; wait_n = 1'b1;
    repeat (3) step();
    n_cmp++;
    if ({mem_rbusy, mreq_n, rd_n} !== {1'b0, 2'b11, 1'b1}) begin
      n_err++; $display("FAIL rst_discard: busy=%b mreq=%b rd=%b want 0 11 1",
                        mem_rbusy, mreq_n, rd_n);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    step();
    test_write_hi();
    test_write_lo();
    test_io_read();
    test_wait();
    step();
    test_busrq();
    step();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
